mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
Multi-cycle MIPS control FSM that issues the 3-bit ALU op code and all datapath steering and enable signals, one instruction at a time. Sits between the instruction register (opcode/funct), the ALU zero flag, and a single shared instruction/data memory port with a req/ack handshake. Supports R-type add/sub/and/or/slt, lw, sw, beq, j and addi. Any other encoding traps.

Parameters:
RESET_STATE, 0 (FETCH), state entered on reset
TRAP_STICKY, 1, 1 = illegal state holds until reset; 0 = pulse illegal for one cycle and return to FETCH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE until the next FETCH
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, same cycle
mem_ack  in  1  memory completes the access in this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, valid with mem_req
iord  out  1  address select: 0 = PC, 1 = ALUOut
ir_write  out  1  load IR
reg_write  out  1  register file write
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
alu_src_a  out  1  0 = PC, 1 = regA
alu_src_b  out  2  00 = regB, 01 = const 4, 10 = sext(imm), 11 = sext(imm)<<2
alu_op  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}
pc_write  out  1  PC load enable
retire  out  1  one-cycle pulse in the final state of each completed instruction
illegal  out  1  unsupported opcode/funct detected

Behaviour:
- Reset (async, rst_n = 0): state = FETCH; every output = 0 except alu_op = 010. mem_req deasserts immediately, including when reset hits mid-access.
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, TRAP.
- FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 010, pc_src = 00. ir_write and pc_write are Mealy: asserted only in the cycle where mem_ack = 1, then go to DECODE. Without mem_ack, hold FETCH with all strobes at 0.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = add (computes branch target into ALUOut). Next state:
  - op 0x00 with funct 0x20/22/24/25/2A -> EXEC_R
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x08 -> EXEC_I
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - anything else -> TRAP
- EXEC_R: alu_src_a = 1, alu_src_b = 00. alu_op from funct: 20 -> 010, 22 -> 110, 24 -> 000, 25 -> 001, 2A -> 111. Next R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, retire = 1. Next FETCH.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, alu_op = 010. Next I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, retire = 1.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 010. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req = 1, iord = 1. Hold until mem_ack, then MEM_WB.
- MEM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 1, retire = 1.
- MEM_WR: mem_req = 1, mem_we = 1, iord = 1. On mem_ack: retire = 1 (Mealy), next FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 110, pc_src = 01, pc_write = zero (Mealy), retire = 1. Next FETCH.
- JUMP: pc_src = 10, pc_write = 1, retire = 1. Next FETCH.
- TRAP:
  - TRAP_STICKY = 1: illegal = 1 and state held until reset; no memory requests.
  - TRAP_STICKY = 0: illegal pulses for one cycle, then FETCH.
- Latency with zero-wait memory: R-type / addi / sw = 4 cycles, lw = 5, beq / j = 3. Each wait cycle adds 1.
- mem_ack while mem_req = 0 is ignored. mem_req never drops before its ack except on reset.
- Unlisted outputs are 0 in every state; alu_op defaults to 010.

Optional Feature:
MIPS_CTRL_RETIRE_CNT_EN: adds output port retire_cnt[31:0]. It resets to 0, increments on each retire pulse, and wraps from 0xFFFFFFFF to 0. Without the macro, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- rst_n low for 2 cycles, then high -> all strobes 0, alu_op = 010, mem_req = 1 in FETCH on the first cycle after release.
- R-type funct 0x22 with mem_ack tied 1 -> alu_op = 110 in EXEC_R; reg_write = 1 and reg_dst = 1 in cycle 4; retire once.
- lw (0x23) with mem_ack delayed 3 cycles in MEM_RD -> mem_req held 4 cycles with iord = 1; mem_to_reg = 1 in MEM_WB; 8 cycles total.
- beq (0x04) twice, zero = 1 then zero = 0 -> pc_write = 1 with pc_src = 01 the first time; pc_write = 0 the second; both take 3 cycles.
- opcode 0x3F with TRAP_STICKY = 1 -> illegal held high for 20 cycles with no mem_req; reset clears it.
- rst_n asserted mid-MEM_WR (mem_req = 1, no ack) -> mem_req and mem_we drop in the same cycle; FETCH after release; with MIPS_CTRL_RETIRE_CNT_EN, retire_cnt = 0.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips_mc_ctrl
// Purpose  : Multi-cycle MIPS control FSM. Sequences one instruction at a
//            time through fetch/decode/execute/memory/writeback and drives
//            the ALU op code plus all datapath steering and enable strobes.
//            Supports R-type add/sub/and/or/slt, lw, sw, beq, j, addi; any
//            other encoding enters TRAP.
// Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//            opcode, funct       - IR[31:26], IR[5:0]
//            zero                - ALU zero flag (same cycle)
//            mem_ack             - shared memory port completes access
//            mem_req, mem_we     - shared memory port request / write strobe
//            iord                - memory address select (0 PC, 1 ALUOut)
//            ir_write, pc_write  - IR / PC load enables
//            pc_src              - PC source select
//            reg_write, reg_dst, mem_to_reg - register file write controls
//            alu_src_a, alu_src_b, alu_op   - ALU operand / operation select
//            retire              - pulse in final state of each instruction
//            illegal             - unsupported encoding detected
//            retire_cnt          - retired instruction count (optional)
// Options  : `define MIPS_CTRL_RETIRE_CNT_EN adds the retire_cnt[31:0] port
//            and its wrapping counter.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl #(
    parameter int RESET_STATE = 0,  // state encoding entered on reset (0 = FETCH)
    parameter bit TRAP_STICKY = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        pc_write,
    output logic        retire,
    output logic        illegal
`ifdef MIPS_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] c_fetch    = 4'd0;
    localparam logic [3:0] c_decode   = 4'd1;
    localparam logic [3:0] c_mem_addr = 4'd2;
    localparam logic [3:0] c_mem_rd   = 4'd3;
    localparam logic [3:0] c_mem_wb   = 4'd4;
    localparam logic [3:0] c_mem_wr   = 4'd5;
    localparam logic [3:0] c_exec_r   = 4'd6;
    localparam logic [3:0] c_r_wb     = 4'd7;
    localparam logic [3:0] c_exec_i   = 4'd8;
    localparam logic [3:0] c_i_wb     = 4'd9;
    localparam logic [3:0] c_branch   = 4'd10;
    localparam logic [3:0] c_jump     = 4'd11;
    localparam logic [3:0] c_trap     = 4'd12;

    localparam logic [3:0] c_reset_st = 4'(RESET_STATE);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [2:0] c_alu_and  = 3'b000;
    localparam logic [2:0] c_alu_or   = 3'b001;
    localparam logic [2:0] c_alu_add  = 3'b010;
    localparam logic [2:0] c_alu_sub  = 3'b110;
    localparam logic [2:0] c_alu_slt  = 3'b111;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [2:0] w_r_alu_op;
    logic       w_funct_ok;

    // ------------------------------------------------------------------
    // R-type funct decode, shared by DECODE (legality) and EXEC_R (op)
    // ------------------------------------------------------------------
    always_comb begin
        w_r_alu_op = c_alu_add;
        w_funct_ok = 1'b1;
        case (funct)
            6'h20:   w_r_alu_op = c_alu_add;
            6'h22:   w_r_alu_op = c_alu_sub;
            6'h24:   w_r_alu_op = c_alu_and;
            6'h25:   w_r_alu_op = c_alu_or;
            6'h2A:   w_r_alu_op = c_alu_slt;
            default: w_funct_ok = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_reset_st;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_fetch:    w_next_state = mem_ack ? c_decode : c_fetch;
            c_decode: begin
                case (opcode)
                    c_op_rtype: w_next_state = w_funct_ok ? c_exec_r : c_trap;
                    c_op_lw,
                    c_op_sw:    w_next_state = c_mem_addr;
                    c_op_addi:  w_next_state = c_exec_i;
                    c_op_beq:   w_next_state = c_branch;
                    c_op_j:     w_next_state = c_jump;
                    default:    w_next_state = c_trap;
                endcase
            end
            c_exec_r:   w_next_state = c_r_wb;
            c_r_wb:     w_next_state = c_fetch;
            c_exec_i:   w_next_state = c_i_wb;
            c_i_wb:     w_next_state = c_fetch;
            // opcode is stable here and can only be lw or sw
            c_mem_addr: w_next_state = (opcode == c_op_sw) ? c_mem_wr : c_mem_rd;
            c_mem_rd:   w_next_state = mem_ack ? c_mem_wb : c_mem_rd;
            c_mem_wb:   w_next_state = c_fetch;
            c_mem_wr:   w_next_state = mem_ack ? c_fetch : c_mem_wr;
            c_branch:   w_next_state = c_fetch;
            c_jump:     w_next_state = c_fetch;
            c_trap:     w_next_state = TRAP_STICKY ? c_trap : c_fetch;
            // Unused encodings recover to FETCH
            default:    w_next_state = c_fetch;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. Outputs are forced to their idle values while rst_n
    // is low so a request in flight drops the moment reset asserts, not
    // at the next clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = c_alu_add;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            case (r_state)
                c_fetch: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;     // PC + 4
                    ir_write  = mem_ack;
                    pc_write  = mem_ack;
                end
                c_decode: begin
                    alu_src_b = 2'b11;     // branch target into ALUOut
                end
                c_exec_r: begin
                    alu_src_a = 1'b1;
                    alu_op    = w_r_alu_op;
                end
                c_r_wb: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                end
                c_exec_i, c_mem_addr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                c_i_wb: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                c_mem_rd: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                c_mem_wb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                c_mem_wr: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    retire  = mem_ack;
                end
                c_branch: begin
                    alu_src_a = 1'b1;
                    alu_op    = c_alu_sub;
                    pc_src    = 2'b01;
                    pc_write  = zero;
                    retire    = 1'b1;
                end
                c_jump: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end
                c_trap: begin
                    illegal = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MIPS_CTRL_RETIRE_CNT_EN
    // ------------------------------------------------------------------
    // Retired-instruction counter, wraps naturally at 2^32
    // ------------------------------------------------------------------
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= 32'd0;
        end else if (retire) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_ctrl
// Purpose  : Self-checking bench for mips_mc_ctrl. Each cycle the expected
//            output vector is pushed to a scoreboard queue as the inputs are
//            driven and popped for comparison at the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       retire;
        logic       illegal;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ack;
    logic        mem_req, mem_we, iord, ir_write, reg_write, reg_dst;
    logic        mem_to_reg, alu_src_a, pc_write, retire, illegal;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_op;
`ifdef MIPS_CTRL_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 32'd0;
    out_t        exp_q[$];

    always #5 clk = ~clk;

    mips_mc_ctrl #(.RESET_STATE(0), .TRAP_STICKY(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .pc_write   (pc_write),
        .retire     (retire),
        .illegal    (illegal)
`ifdef MIPS_CTRL_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    // ---------------- expected vectors, one per architectural state ----
    function automatic out_t e_idle();
        out_t o = '0;
        o.alu_op = 3'b010;
        return o;
    endfunction
    function automatic out_t e_fetch(input logic ack);
        out_t o = e_idle();
        o.mem_req = 1'b1; o.alu_src_b = 2'b01; o.ir_write = ack; o.pc_write = ack;
        return o;
    endfunction
    function automatic out_t e_decode();
        out_t o = e_idle();
        o.alu_src_b = 2'b11;
        return o;
    endfunction
    function automatic out_t e_exec_r(input logic [2:0] op);
        out_t o = e_idle();
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b00; o.alu_op = op;
        return o;
    endfunction
    function automatic out_t e_r_wb();
        out_t o = e_idle();
        o.reg_write = 1'b1; o.reg_dst = 1'b1; o.retire = 1'b1;
        return o;
    endfunction
    function automatic out_t e_addr_calc();   // EXEC_I and MEM_ADDR
        out_t o = e_idle();
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        return o;
    endfunction
    function automatic out_t e_i_wb();
        out_t o = e_idle();
        o.reg_write = 1'b1; o.retire = 1'b1;
        return o;
    endfunction
    function automatic out_t e_mem_rd();
        out_t o = e_idle();
        o.mem_req = 1'b1; o.iord = 1'b1;
        return o;
    endfunction
    function automatic out_t e_mem_wb();
        out_t o = e_idle();
        o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.retire = 1'b1;
        return o;
    endfunction
    function automatic out_t e_mem_wr(input logic ack);
        out_t o = e_idle();
        o.mem_req = 1'b1; o.mem_we = 1'b1; o.iord = 1'b1; o.retire = ack;
        return o;
    endfunction
    function automatic out_t e_branch(input logic z);
        out_t o = e_idle();
        o.alu_src_a = 1'b1; o.alu_op = 3'b110; o.pc_src = 2'b01;
        o.pc_write = z; o.retire = 1'b1;
        return o;
    endfunction
    function automatic out_t e_jump();
        out_t o = e_idle();
        o.pc_src = 2'b10; o.pc_write = 1'b1; o.retire = 1'b1;
        return o;
    endfunction
    function automatic out_t e_trap();
        out_t o = e_idle();
        o.illegal = 1'b1;
        return o;
    endfunction

    function automatic out_t observe();
        out_t o;
        o.mem_req = mem_req;       o.mem_we = mem_we;         o.iord = iord;
        o.ir_write = ir_write;     o.reg_write = reg_write;   o.reg_dst = reg_dst;
        o.mem_to_reg = mem_to_reg; o.alu_src_a = alu_src_a;   o.alu_src_b = alu_src_b;
        o.alu_op = alu_op;         o.pc_src = pc_src;         o.pc_write = pc_write;
        o.retire = retire;         o.illegal = illegal;
        return o;
    endfunction

    // One clock: drive inputs (just after a rising edge), push expectation,
    // pop and compare at the falling edge, then advance past the next edge.
    task automatic cycle(input logic ack, input logic z, input out_t exp, input string tag);
        out_t got;
        out_t want;
        mem_ack = ack;
        zero    = z;
        exp_q.push_back(exp);
        if (exp.retire) exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
        got  = observe();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
        @(posedge clk);
        #1;
`ifdef MIPS_CTRL_RETIRE_CNT_EN
        n_cmp++;
        if (retire_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL %s retire_cnt: got %0d expected %0d", tag, retire_cnt, exp_cnt);
        end
`endif
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        exp_cnt = 32'd0;
        set_ir(6'h00, 6'h20);
        cycle(1'b1, 1'b0, e_idle(), "reset_c0");
        cycle(1'b1, 1'b0, e_idle(), "reset_c1");
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, e_fetch(1'b0), "reset_first_fetch");
    endtask

    task automatic test_rtype();
        logic [5:0] fn_tab [5] = '{6'h22, 6'h20, 6'h24, 6'h25, 6'h2A};
        logic [2:0] op_tab [5] = '{3'b110, 3'b010, 3'b000, 3'b001, 3'b111};
        for (int i = 0; i < 5; i++) begin
            set_ir(6'h00, fn_tab[i]);
            cycle(1'b1, 1'b0, e_fetch(1'b1), "rtype_fetch");
            cycle(1'b1, 1'b0, e_decode(), "rtype_decode");
            cycle(1'b1, 1'b0, e_exec_r(op_tab[i]), "rtype_exec");
            cycle(1'b1, 1'b0, e_r_wb(), "rtype_wb");
        end
    endtask

    task automatic test_addi();
        set_ir(6'h08, 6'h3F);
        cycle(1'b1, 1'b0, e_fetch(1'b1), "addi_fetch");
        cycle(1'b0, 1'b0, e_decode(), "addi_decode");
        cycle(1'b0, 1'b0, e_addr_calc(), "addi_exec");
        cycle(1'b0, 1'b0, e_i_wb(), "addi_wb");
    endtask

    task automatic test_lw_wait();
        set_ir(6'h23, 6'h00);
        cycle(1'b1, 1'b0, e_fetch(1'b1), "lw_fetch");
        cycle(1'b0, 1'b0, e_decode(), "lw_decode");
        cycle(1'b0, 1'b0, e_addr_calc(), "lw_addr");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, e_mem_rd(), "lw_rd_wait");
        cycle(1'b1, 1'b0, e_mem_rd(), "lw_rd_ack");
        cycle(1'b0, 1'b0, e_mem_wb(), "lw_wb");
    endtask

    task automatic test_sw();
        set_ir(6'h2B, 6'h00);
        cycle(1'b0, 1'b0, e_fetch(1'b0), "sw_fetch_wait");
        cycle(1'b1, 1'b0, e_fetch(1'b1), "sw_fetch");
        cycle(1'b0, 1'b0, e_decode(), "sw_decode");
        cycle(1'b0, 1'b0, e_addr_calc(), "sw_addr");
        cycle(1'b0, 1'b0, e_mem_wr(1'b0), "sw_wr_wait");
        cycle(1'b1, 1'b0, e_mem_wr(1'b1), "sw_wr_ack");
    endtask

    task automatic test_beq();
        logic z_tab [2] = '{1'b1, 1'b0};
        set_ir(6'h04, 6'h00);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, ~z_tab[i], e_fetch(1'b1), "beq_fetch");
            cycle(1'b1, ~z_tab[i], e_decode(), "beq_decode");
            cycle(1'b1, z_tab[i], e_branch(z_tab[i]), "beq_branch");
        end
    endtask

    task automatic test_jump();
        set_ir(6'h02, 6'h00);
        cycle(1'b1, 1'b0, e_fetch(1'b1), "j_fetch");
        cycle(1'b0, 1'b0, e_decode(), "j_decode");
        cycle(1'b0, 1'b0, e_jump(), "j_jump");
    endtask

    task automatic test_reset_mid_wr();
        out_t got;
        out_t want;
        set_ir(6'h2B, 6'h00);
        cycle(1'b1, 1'b0, e_fetch(1'b1), "rstwr_fetch");
        cycle(1'b0, 1'b0, e_decode(), "rstwr_decode");
        cycle(1'b0, 1'b0, e_addr_calc(), "rstwr_addr");
        mem_ack = 1'b0;
        exp_q.push_back(e_mem_wr(1'b0));
        @(negedge clk);
        got  = observe();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL rstwr_in_wr: got %h expected %h", got, want);
        end
        #1 rst_n = 1'b0;
        exp_cnt = 32'd0;
        exp_q.push_back(e_idle());
        #1;
        got  = observe();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL rstwr_same_cycle_drop: got %h expected %h", got, want);
        end
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b0, e_idle(), "rstwr_hold");
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, e_fetch(1'b0), "rstwr_fetch_after");
    endtask

    task automatic test_trap(input logic [5:0] op, input logic [5:0] fn, input int hold);
        set_ir(op, fn);
        cycle(1'b1, 1'b0, e_fetch(1'b1), "trap_fetch");
        cycle(1'b1, 1'b0, e_decode(), "trap_decode");
        for (int i = 0; i < hold; i++) cycle(1'b1, 1'b1, e_trap(), "trap_hold");
        rst_n   = 1'b0;
        exp_cnt = 32'd0;
        cycle(1'b1, 1'b0, e_idle(), "trap_in_reset");
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, e_fetch(1'b0), "trap_fetch_after_reset");
    endtask

    initial begin
        rst_n   = 1'b0;
        opcode  = 6'h00;
        funct   = 6'h00;
        zero    = 1'b0;
        mem_ack = 1'b0;
        test_reset();
        test_rtype();
        test_addi();
        test_lw_wait();
        test_sw();
        test_beq();
        test_jump();
        test_reset_mid_wr();
        test_trap(6'h3F, 6'h00, 20);
        test_trap(6'h00, 6'h21, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
